// File: rtl/product_accumulator.sv
// Frame accumulator for the 26-bit signed Booth product stream: sums products
// until LAST or MAX_TERMS, then holds the result. Optional macro: ACC_SATURATE_EN.
module product_accumulator #(
    parameter int ACC_WIDTH = 32,
    parameter int MAX_TERMS = 256,
    parameter int CNT_WIDTH = $clog2(MAX_TERMS + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 prod_valid_i,
    output logic                 prod_ready_o,
    input  logic [25:0]          prod_num_i,
    input  logic                 prod_last_i,
    output logic                 acc_valid_o,
    input  logic                 acc_ready_i,
    output logic [ACC_WIDTH-1:0] acc_num_o,
    output logic [CNT_WIDTH-1:0] acc_cnt_o,
    output logic                 acc_ovf_o,
    output logic                 acc_trunc_o
);
    typedef enum logic {ACCUM, HOLD} state_t;

    localparam int MSB = ACC_WIDTH - 1;
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_TERMS);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic                 trunc_q, trunc_d;
    logic                 ready_q, ready_d;

    logic [ACC_WIDTH-1:0] ext, sum_raw, sum;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 sum_ovf, accept, at_max;

    always_comb begin
        ext     = {{(ACC_WIDTH-26){prod_num_i[25]}}, prod_num_i};
        sum_raw = acc_q + ext;
        sum_ovf = (acc_q[MSB] == ext[MSB]) && (sum_raw[MSB] != acc_q[MSB]);
`ifdef ACC_SATURATE_EN
        // Clamp toward the sign of the operands; later terms add onto the clamp.
        sum     = sum_ovf ? (acc_q[MSB] ? ACC_MIN : ACC_MAX) : sum_raw;
`else
        sum     = sum_raw;
`endif
        cnt_inc = cnt_q + 1'b1;
        at_max  = (cnt_inc == MAX_CNT);
        accept  = prod_valid_i & ready_q;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        trunc_d = trunc_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d = sum;
                    cnt_d = cnt_inc;
                    ovf_d = ovf_q | sum_ovf;
                    if (prod_last_i || at_max) begin
                        state_d = HOLD;
                        trunc_d = at_max & ~prod_last_i;
                    end
                end
            end
            HOLD: begin
                if (acc_ready_i) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    trunc_d = 1'b0;
                end
            end
            default: state_d = ACCUM;
        endcase
        // Ready stays low through the handshake cycle: one bubble per frame.
        ready_d = (state_d == ACCUM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            trunc_q <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            trunc_q <= trunc_d;
            ready_q <= ready_d;
        end
    end

    assign prod_ready_o = ready_q;
    assign acc_valid_o  = (state_q == HOLD);
    assign acc_num_o    = acc_q;
    assign acc_cnt_o    = cnt_q;
    assign acc_ovf_o    = ovf_q;
    assign acc_trunc_o  = trunc_q;
endmodule
